writeback_controller: RTL and testbench

WRITEBACK_CONTROLLER -- requirements
Module: writeback_controller

---
 rtl/writeback_controller_pkg.sv | 27 ++
 rtl/writeback_controller_load_extend.sv | 56 +++++
 rtl/writeback_controller.sv | 160 ++++++++++++++++
 tb/tb_writeback_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_controller_pkg
//  Description : Shared load-type codes, FSM state encoding and the
//                memory-wait timeout constant for the writeback controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_controller_pkg;

   // Load type codes carried on in_ld_type
   localparam logic [2:0] c_LD_LB  = 3'd0;
   localparam logic [2:0] c_LD_LH  = 3'd1;
   localparam logic [2:0] c_LD_LW  = 3'd3;
   localparam logic [2:0] c_LD_LBU = 3'd4;
   localparam logic [2:0] c_LD_LHU = 3'd5;

   // Number of WAIT_MEM cycles after which a load is abandoned
   localparam logic [7:0] c_TIMEOUT_CYCLES = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_COMMIT   = 2'd2
   } wb_state_e;

endpackage : writeback_controller_pkg
`default_nettype wire

// File: rtl/writeback_controller_load_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_extend
//  Description : Big-endian byte/halfword lane selection with sign or zero
//                extension; flags misaligned accesses and undefined types.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extend
   import writeback_controller_pkg::*;
(
   input  logic [2:0]  ld_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed lane; byte 0 is the most significant byte of the word
   always_comb begin
      case (addr_lo)
         2'd0:    w_byte = rdata[31:24];
         2'd1:    w_byte = rdata[23:16];
         2'd2:    w_byte = rdata[15:8];
         default: w_byte = rdata[7:0];
      endcase
      w_half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   // Extend the selected lane and report accesses that cannot be honoured
   always_comb begin
      data       = '0;
      misaligned = 1'b0;
      case (ld_type)
         c_LD_LB:  data = {{24{w_byte[7]}}, w_byte};
         c_LD_LBU: data = {24'd0, w_byte};
         c_LD_LH: begin
            data       = {{16{w_half[15]}}, w_half};
            misaligned = addr_lo[0];
         end
         c_LD_LHU: begin
            data       = {16'd0, w_half};
            misaligned = addr_lo[0];
         end
         c_LD_LW: begin
            data       = rdata;
            misaligned = (addr_lo != 2'd0);
         end
         default:  misaligned = 1'b1;
      endcase
   end

endmodule : load_extend
`default_nettype wire

// File: rtl/writeback_controller.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_controller
//  Description : Writeback stage controller. Commits ALU results one cycle
//                after acceptance, waits for memory on loads (with timeout),
//                extends load data and exposes load-use hazard information.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_controller
   import writeback_controller_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wen,
   input  logic [4:0]  in_rd,
   input  logic        in_is_load,
   input  logic [2:0]  in_ld_type,
   input  logic [1:0]  in_addr_lo,
   input  logic [31:0] in_alu_result,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall,
   output logic        pending_valid,
   output logic [4:0]  pending_rd,
   output logic        align_err,
   output logic        timeout_err
);

   wb_state_e   r_state;
   wb_state_e   w_next_state;

   logic [4:0]  r_rd;
   logic        r_wen;
   logic [2:0]  r_ld_type;
   logic [1:0]  r_addr_lo;
   logic [31:0] r_data;
   logic [7:0]  r_cnt;
   logic        r_align_err;
   logic        r_timeout_err;

   logic        w_accept;
   logic        w_in_ready;
   logic        w_load_done;
   logic        w_align_fail;
   logic        w_timeout;
   logic [7:0]  w_cnt_inc;
   logic [31:0] w_ext_data;
   logic        w_misaligned;
   logic        w_rd_nonzero;

   // Extraction works on the latched request so the offer bus is free while waiting
   load_extend u_load_extend (
      .ld_type    (r_ld_type),
      .addr_lo    (r_addr_lo),
      .rdata      (mem_rdata),
      .data       (w_ext_data),
      .misaligned (w_misaligned)
   );

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; w_cnt_inc is the number of WAIT_MEM cycles including
   // the current one, so the timeout fires in the 255th waiting cycle
   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b1;
      w_accept     = 1'b0;
      w_load_done  = 1'b0;
      w_align_fail = 1'b0;
      w_timeout    = 1'b0;
      w_cnt_inc    = r_cnt + 8'd1;
      case (r_state)
         ST_IDLE, ST_COMMIT: begin
            w_accept = in_valid;
            if (in_valid) begin
               w_next_state = in_is_load ? ST_WAIT_MEM : ST_COMMIT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT_MEM: begin
            w_in_ready = 1'b0;
            if (mem_rvalid) begin
               if (w_misaligned) begin
                  w_align_fail = 1'b1;
                  w_next_state = ST_IDLE;
               end else begin
                  w_load_done  = 1'b1;
                  w_next_state = ST_COMMIT;
               end
            end else if (w_cnt_inc == c_TIMEOUT_CYCLES) begin
               w_timeout    = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Request latch, wait counter, result register and sticky error flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd          <= '0;
         r_wen         <= 1'b0;
         r_ld_type     <= '0;
         r_addr_lo     <= '0;
         r_data        <= '0;
         r_cnt         <= '0;
         r_align_err   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rd      <= in_rd;
            r_wen     <= in_wen;
            r_ld_type <= in_ld_type;
            r_addr_lo <= in_addr_lo;
            r_cnt     <= '0;
            if (!in_is_load) begin
               r_data <= in_alu_result;
            end
         end else if (r_state == ST_WAIT_MEM) begin
            r_cnt <= w_cnt_inc;
            if (w_load_done) begin
               r_data <= w_ext_data;
            end
         end
         if (w_align_fail) begin
            r_align_err <= 1'b1;
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign w_rd_nonzero  = (r_rd != 5'd0);
   assign in_ready      = w_in_ready;
   assign rf_we         = (r_state == ST_COMMIT) && r_wen && w_rd_nonzero;
   assign rf_waddr      = r_rd;
   assign rf_wdata      = r_data;
   assign stall         = (r_state == ST_WAIT_MEM);
   assign pending_valid = stall && r_wen && w_rd_nonzero;
   assign pending_rd    = pending_valid ? r_rd : 5'd0;
   assign align_err     = r_align_err;
   assign timeout_err   = r_timeout_err;

endmodule : writeback_controller
`default_nettype wire

// File: tb/tb_writeback_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_controller
//  Description : Self-checking bench for writeback_controller; expected
//                register-file writes are queued and matched at the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_controller;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_wen;
   logic [4:0]  in_rd;
   logic        in_is_load;
   logic [2:0]  in_ld_type;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu_result;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall;
   logic        pending_valid;
   logic [4:0]  pending_rd;
   logic        align_err;
   logic        timeout_err;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   writeback_controller dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_wen        (in_wen),
      .in_rd         (in_rd),
      .in_is_load    (in_is_load),
      .in_ld_type    (in_ld_type),
      .in_addr_lo    (in_addr_lo),
      .in_alu_result (in_alu_result),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .stall         (stall),
      .pending_valid (pending_valid),
      .pending_rd    (pending_rd),
      .align_err     (align_err),
      .timeout_err   (timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Reference load behaviour: shift the addressed lane down, then extend
   task automatic ld_model(input logic [2:0] t, input logic [1:0] a, input logic [31:0] w,
                           output logic [31:0] res, output logic bad);
      logic [7:0]  b;
      logic [15:0] h;
      b   = 8'(w >> (8 * (3 - int'(a))));
      h   = 16'(w >> (16 * (1 - int'(a[1]))));
      bad = 1'b0;
      res = 32'd0;
      case (t)
         3'd0: res = 32'($signed(b));
         3'd4: res = 32'(b);
         3'd1: begin res = 32'($signed(h)); bad = a[0]; end
         3'd5: begin res = 32'(h);          bad = a[0]; end
         3'd3: begin res = w;               bad = (a != 2'd0); end
         default: bad = 1'b1;
      endcase
   endtask

   // Write-port monitor: every write must match the oldest expected one
   always @(negedge clock) begin
      if (reset_n && rf_we) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_we", 32'(rf_we), 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("sb_waddr", 32'(rf_waddr), 32'(e.addr));
            chk("sb_wdata", rf_wdata, e.data);
         end
      end
   end

   task automatic reset_outs();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pend_v", 32'(pending_valid), 32'd0);
      chk("rst_pend_rd", 32'(pending_rd), 32'd0);
      chk("rst_align", 32'(align_err), 32'd0);
      chk("rst_timeout", 32'(timeout_err), 32'd0);
   endtask

   // Offer one ALU result; the bench is left in the COMMIT cycle
   task automatic alu(input logic [4:0] rd, input logic [31:0] d, input logic wen);
      logic will_write;
      will_write    = wen && (rd != 5'd0);
      in_valid      = 1'b1;
      in_is_load    = 1'b0;
      in_wen        = wen;
      in_rd         = rd;
      in_ld_type    = 3'd0;
      in_addr_lo    = 2'd0;
      in_alu_result = d;
      if (will_write) sb.push_back('{addr: rd, data: d});
      cyc();
      chk("alu_we", 32'(rf_we), 32'(will_write));
      if (will_write) begin
         chk("alu_waddr", 32'(rf_waddr), 32'(rd));
         chk("alu_wdata", rf_wdata, d);
      end
   endtask

   // Offer a load and return mem data in the delay-th WAIT_MEM cycle
   task automatic do_load(input logic [2:0] t, input logic [1:0] a, input logic [4:0] rd,
                          input logic [31:0] rdata, input int delay);
      logic [31:0] exp;
      logic        bad;
      logic        will_write;
      int          n;
      ld_model(t, a, rdata, exp, bad);
      will_write    = !bad && (rd != 5'd0);
      in_valid      = 1'b1;
      in_is_load    = 1'b1;
      in_wen        = 1'b1;
      in_rd         = rd;
      in_ld_type    = t;
      in_addr_lo    = a;
      in_alu_result = 32'hDEAD_BEEF;
      cyc();
      in_valid = 1'b0;
      chk("ld_ready", 32'(in_ready), 32'd0);
      chk("ld_pend_v", 32'(pending_valid), 32'(rd != 5'd0));
      chk("ld_pend_rd", 32'(pending_rd), 32'(rd));
      if (will_write) sb.push_back('{addr: rd, data: exp});
      n = 0;
      for (int k = 1; k <= delay; k++) begin
         if (stall) n++;
         if (k == delay) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
         end
         cyc();
      end
      mem_rvalid = 1'b0;
      chk("ld_stall_cycles", 32'(n), 32'(delay));
      chk("ld_we", 32'(rf_we), 32'(will_write));
      if (bad) chk("ld_align_err", 32'(align_err), 32'd1);
      if (will_write) chk("ld_wdata", rf_wdata, exp);
      cyc();
      chk("ld_stall_after", 32'(stall), 32'd0);
   endtask

   initial begin
      int n;
      reset_n       = 1'b0;
      in_valid      = 1'b0;
      in_wen        = 1'b0;
      in_rd         = '0;
      in_is_load    = 1'b0;
      in_ld_type    = '0;
      in_addr_lo    = '0;
      in_alu_result = '0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      cyc();
      cyc();
      reset_outs();
      reset_n = 1'b1;
      cyc();

      // Stray memory response in IDLE must be ignored
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_5555;
      cyc();
      mem_rvalid = 1'b0;
      chk("idle_rvalid_we", 32'(rf_we), 32'd0);

      // Single ALU op, then return to IDLE
      alu(5'd5, 32'h1234_5678, 1'b1);
      in_valid = 1'b0;
      cyc();
      chk("alu_idle_we", 32'(rf_we), 32'd0);

      // Back-to-back ALU ops, one write per cycle
      alu(5'd1, 32'h0000_0011, 1'b1);
      alu(5'd2, 32'h0000_0022, 1'b1);
      alu(5'd3, 32'h0000_0033, 1'b1);
      in_valid = 1'b0;
      cyc();

      // Register 0 and wen=0 never write
      alu(5'd0, 32'hFFFF_FFFF, 1'b1);
      alu(5'd7, 32'hAAAA_0000, 1'b0);
      in_valid = 1'b0;
      cyc();

      // Loads
      do_load(3'd0, 2'd1, 5'd9,  32'h00F0_0000, 3);
      do_load(3'd5, 2'd2, 5'd10, 32'hAAAA_8001, 1);
      do_load(3'd4, 2'd3, 5'd13, 32'h1234_56F7, 2);
      do_load(3'd1, 2'd2, 5'd14, 32'h0000_9ABC, 1);
      do_load(3'd3, 2'd0, 5'd12, 32'hCAFE_F00D, 255);
      chk("rvalid255_no_timeout", 32'(timeout_err), 32'd0);
      do_load(3'd1, 2'd1, 5'd11, 32'h1234_5678, 1);
      do_load(3'd2, 2'd0, 5'd15, 32'h1234_5678, 1);

      // Timeout with no memory response
      in_valid   = 1'b1;
      in_is_load = 1'b1;
      in_wen     = 1'b1;
      in_rd      = 5'd16;
      in_ld_type = 3'd3;
      in_addr_lo = 2'd0;
      cyc();
      in_valid = 1'b0;
      n = 0;
      while (stall && n < 300) begin
         n++;
         cyc();
      end
      chk("to_cycles", 32'(n), 32'd255);
      chk("to_err", 32'(timeout_err), 32'd1);
      chk("to_we", 32'(rf_we), 32'd0);
      chk("to_ready", 32'(in_ready), 32'd1);

      // Reset in WAIT_MEM abandons the load
      in_valid   = 1'b1;
      in_rd      = 5'd17;
      in_ld_type = 3'd0;
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("rst_wait_stall", 32'(stall), 32'd1);
      reset_n = 1'b0;
      #1;
      reset_outs();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8080_8080;
      cyc();
      reset_n = 1'b1;
      cyc();
      chk("rst_abandon_we", 32'(rf_we), 32'd0);
      mem_rvalid = 1'b0;
      cyc();
      chk("rst_abandon_we2", 32'(rf_we), 32'd0);
      chk("rst_abandon_stall", 32'(stall), 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_writeback_controller
`default_nettype wire
